alu_mdu: RTL and testbench

Parametrised successor to the single-cycle datapath ALU. It adds an iterative multiply/divide unit with HI/LO registers, a valid/ready input handshake, and registered outputs. It sits in the EX stage of the multi-cycle MIPS core. Logic/shift/add ops complete in one cycle at full throughput; MULT/DIV ops stall the issuing stage via `in_ready`.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_mdu_core.sv | 138 +++++++++++++
 rtl/alu_mdu.sv | 98 +++++++++
 tb/tb_alu_mdu.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, multiply/divide FSM states and issue helpers shared by
// alu_mdu and alu_mdu_core.
// Build option: define ALU_MDU_DIV_EN to include the iterative divider.
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SLTU  = 4'b0011;
  localparam logic [3:0] ALU_SLL   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_MULT  = 4'b1000;
  localparam logic [3:0] ALU_MULTU = 4'b1001;
  localparam logic [3:0] ALU_DIV   = 4'b1010;
  localparam logic [3:0] ALU_DIVU  = 4'b1011;
  localparam logic [3:0] ALU_MFHI  = 4'b1100;
  localparam logic [3:0] ALU_MFLO  = 4'b1101;
  localparam logic [3:0] ALU_SRA   = 4'b1110;
  localparam logic [3:0] ALU_RSVD  = 4'b1111;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  // True for opcodes handed to the iterative engine. Without the divider,
  // DIV/DIVU stay single-cycle and are reported as illegal.
  function automatic logic is_multicycle(input logic [3:0] op);
`ifdef ALU_MDU_DIV_EN
    return (op == ALU_MULT) || (op == ALU_MULTU) || (op == ALU_DIV) || (op == ALU_DIVU);
`else
    return (op == ALU_MULT) || (op == ALU_MULTU);
`endif
  endfunction

endpackage

// File: rtl/alu_mdu_core.sv
// alu_mdu_core: iterative multiply/divide engine with HI/LO registers.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes,
// with sign correction applied in the FIX state.
// Build option: define ALU_MDU_DIV_EN to include the divider step and DIV state.
module alu_mdu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             div_sel,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             idle,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic             res_dbz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  // Steps are taken on WIDTH-1 MUL/DIV edges plus the FIX edge, so the
  // counter starts one below WIDTH-1 to keep the op at WIDTH+1 cycles.
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 2);

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, step, prod;
  logic [WIDTH-1:0]   mag_b, mag_a_in, mag_b_in, res_hi;
  logic [WIDTH:0]     mul_sum;
  logic               div_op, neg_q, neg_r, dbz;
  logic               sign_a, sign_b;
`ifdef ALU_MDU_DIV_EN
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
`endif

  assign sign_a   = sgn & a[WIDTH-1];
  assign sign_b   = sgn & b[WIDTH-1];
  assign mag_a_in = sign_a ? -a : a;
  assign mag_b_in = sign_b ? -b : b;
  assign idle     = (state == IDLE);
  assign done     = (state == FIX);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) begin
`ifdef ALU_MDU_DIV_EN
        state_nxt = div_sel ? DIV : MUL;
`else
        state_nxt = MUL;
`endif
      end
      MUL, DIV: if (cnt == '0) state_nxt = FIX;
      FIX:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // One iteration of the engine: multiplier bits consumed LSB first from
  // acc[WIDTH-1:0]; divide shifts the dividend out of the same half.
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
    step    = {mul_sum, acc[WIDTH-1:1]};
`ifdef ALU_MDU_DIV_EN
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, mag_b});
    div_diff  = div_shift[WIDTH-1:0] - mag_b;
    if (div_op) step = {div_ge ? div_diff : div_shift[WIDTH-1:0], acc[WIDTH-2:0], div_ge};
`endif
  end

  // Final step plus sign correction; divide-by-zero forces an all-ones quotient
  // while the remainder naturally reproduces the dividend.
  always_comb begin
    prod    = neg_q ? -step : step;
    res_hi  = prod[2*WIDTH-1:WIDTH];
    res_lo  = prod[WIDTH-1:0];
    res_dbz = 1'b0;
    if (div_op) begin
      res_lo  = dbz ? '1 : (neg_q ? -step[WIDTH-1:0] : step[WIDTH-1:0]);
      res_hi  = neg_r ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
      res_dbz = dbz;
    end
  end

  // Operand latch at accept, iteration, and HI/LO write-back at FIX.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      mag_b  <= '0;
      div_op <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dbz    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cnt    <= CNT_LOAD;
          acc    <= {{WIDTH{1'b0}}, mag_a_in};
          mag_b  <= mag_b_in;
          div_op <= div_sel;
          neg_q  <= sign_a ^ sign_b;
          neg_r  <= sign_a;
          dbz    <= div_sel & (b == '0);
        end
        MUL, DIV: begin
          acc <= step;
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        FIX: begin
          hi <= res_hi;
          lo <= res_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: EX-stage ALU with single-cycle logic/shift/add ops, an iterative
// MULT/DIV engine (alu_mdu_core), valid/ready issue and registered outputs.
// Build option: define ALU_MDU_DIV_EN to build the divider; otherwise DIV/DIVU
// complete in one cycle as illegal.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [3:0]       ALUCtrl,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             illegal,
  output logic             div_by_zero
);

  logic             accept, multi, core_idle, core_done, core_dbz, sc_illegal;
  logic [WIDTH-1:0] core_lo, hi, lo, sc_result;

  assign in_ready = core_idle;
  assign accept   = in_valid && in_ready;
  assign multi    = is_multicycle(ALUCtrl);

  alu_mdu_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && multi),
    .div_sel (ALUCtrl[1]),
    .sgn     (~ALUCtrl[0]),
    .a       (in0),
    .b       (in1),
    .idle    (core_idle),
    .done    (core_done),
    .res_lo  (core_lo),
    .res_dbz (core_dbz),
    .hi      (hi),
    .lo      (lo)
  );

  // Single-cycle result; anything not listed (reserved, and DIV/DIVU when the
  // divider is absent) is illegal with a zero result.
  always_comb begin
    sc_result  = '0;
    sc_illegal = 1'b0;
    case (ALUCtrl)
      ALU_AND:  sc_result = in0 & in1;
      ALU_OR:   sc_result = in0 | in1;
      ALU_ADD:  sc_result = in0 + in1;
      ALU_SUB:  sc_result = in0 - in1;
      ALU_SLL:  sc_result = in0 << shamt;
      ALU_SRL:  sc_result = in0 >> shamt;
      ALU_SRA:  sc_result = $unsigned($signed(in0) >>> shamt);
      ALU_SLT:  sc_result = {{(WIDTH-1){1'b0}}, $signed(in0) < $signed(in1)};
      ALU_SLTU: sc_result = {{(WIDTH-1){1'b0}}, in0 < in1};
      ALU_MFHI: sc_result = hi;
      ALU_MFLO: sc_result = lo;
      default:  sc_illegal = 1'b1;
    endcase
  end

  // Output registers; a finishing mul/div and a single-cycle accept are
  // mutually exclusive because accept needs the engine idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      ALUResult   <= '0;
      Zero        <= 1'b1;
      illegal     <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (core_done) begin
      out_valid   <= 1'b1;
      ALUResult   <= core_lo;
      Zero        <= (core_lo == '0);
      illegal     <= 1'b0;
      div_by_zero <= core_dbz;
    end else if (accept && !multi) begin
      out_valid   <= 1'b1;
      ALUResult   <= sc_result;
      Zero        <= (sc_result == '0);
      illegal     <= sc_illegal;
      div_by_zero <= 1'b0;
    end else begin
      out_valid   <= 1'b0;
      illegal     <= 1'b0;
      div_by_zero <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed self-checking bench for alu_mdu (WIDTH=32).
// Covers the divider tests when built with ALU_MDU_DIV_EN, the illegal-DIV
// behaviour otherwise.
module tb_alu_mdu;
  import alu_pkg::*;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in0, in1;
  logic [3:0]       ALUCtrl;
  logic [SHW-1:0]   shamt;
  logic             out_valid;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero, illegal, div_by_zero;

  int checks   = 0;
  int failures = 0;

  alu_mdu #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in0         (in0),
    .in1         (in1),
    .ALUCtrl     (ALUCtrl),
    .shamt       (shamt),
    .out_valid   (out_valid),
    .ALUResult   (ALUResult),
    .Zero        (Zero),
    .illegal     (illegal),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request for one clock; returns at the negedge after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    in_valid = 1'b1;
    ALUCtrl  = op;
    in0      = a;
    in1      = b;
    shamt    = sh;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid; caller compares out_valid afterwards.
  task automatic wait_out(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in0 = '0; in1 = '0; ALUCtrl = '0; shamt = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || illegal !== 1'b0 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: out_valid=%b illegal=%b dbz=%b, required 0 0 0", out_valid, illegal, div_by_zero);
    end
    checks++;
    if (ALUResult !== 32'h0 || Zero !== 1'b1) begin
      failures++;
      $display("FAIL reset_result: ALUResult=%h Zero=%b, required 00000000 1", ALUResult, Zero);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: in_ready=%b, required 1", in_ready);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] exp;
  } vec_t;

  task automatic test_single_cycle();
    vec_t v [8];
    v[0] = '{ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000};
    v[1] = '{ALU_SUB, 32'h0000_0005, 32'h0000_0005, 5'd0,  32'h0000_0000};
    v[2] = '{ALU_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0,  32'h00F0_1200};
    v[3] = '{ALU_OR,  32'hF000_0000, 32'h0000_000F, 5'd0,  32'hF000_000F};
    v[4] = '{ALU_SLL, 32'h0000_0001, 32'h0000_0000, 5'd31, 32'h8000_0000};
    v[5] = '{ALU_SRL, 32'h8000_0000, 32'h0000_0000, 5'd4,  32'h0800_0000};
    v[6] = '{ALU_SRA, 32'h8000_0000, 32'h0000_0000, 5'd4,  32'hF800_0000};
    v[7] = '{ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000};
    for (int i = 0; i < 8; i++) begin
      issue(v[i].op, v[i].a, v[i].b, v[i].sh);
      checks++;
      if (out_valid !== 1'b1 || ALUResult !== v[i].exp || Zero !== (v[i].exp == 32'h0) || illegal !== 1'b0) begin
        failures++;
        $display("FAIL single_op%0d: valid=%b result=%h Zero=%b illegal=%b, required 1 %h %b 0",
                 i, out_valid, ALUResult, Zero, illegal, v[i].exp, v[i].exp == 32'h0);
      end
    end
  endtask

  task automatic test_back_to_back();
    issue(ALU_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0);
    checks++;
    if (out_valid !== 1'b1 || ALUResult !== 32'h1) begin
      failures++;
      $display("FAIL b2b_slt: valid=%b result=%h, required 1 00000001", out_valid, ALUResult);
    end
    issue(ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0);
    checks++;
    if (out_valid !== 1'b1 || ALUResult !== 32'h0 || Zero !== 1'b1) begin
      failures++;
      $display("FAIL b2b_sltu: valid=%b result=%h Zero=%b, required 1 00000000 1", out_valid, ALUResult, Zero);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_pulse_end: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_reserved();
    issue(ALU_RSVD, 32'h1234_5678, 32'h1, 5'd3);
    checks++;
    if (out_valid !== 1'b1 || illegal !== 1'b1 || ALUResult !== 32'h0 || Zero !== 1'b1) begin
      failures++;
      $display("FAIL reserved: valid=%b illegal=%b result=%h Zero=%b, required 1 1 00000000 1",
               out_valid, illegal, ALUResult, Zero);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || illegal !== 1'b0) begin
      failures++;
      $display("FAIL reserved_qualify: valid=%b illegal=%b, required 0 0", out_valid, illegal);
    end
  endtask

  task automatic test_mult();
    int bad;
    int n;
    issue(ALU_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 5'd0);
    bad = 0;
    for (int c = 1; c <= 32; c++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL mult_busy: %0d of cycles 1-32 had in_ready/out_valid high, required 0", bad);
    end
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mult_latency: cycle 33 valid=%b ready=%b, required 1 1", out_valid, in_ready);
    end
    checks++;
    if (ALUResult !== 32'hFFFF_FFEB || illegal !== 1'b0 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL mult_lo: result=%h illegal=%b dbz=%b, required ffffffeb 0 0", ALUResult, illegal, div_by_zero);
    end
    // MFHI issued in the out_valid cycle sees the new HI.
    issue(ALU_MFHI, 32'h0, 32'h0, 5'd0);
    checks++;
    if (out_valid !== 1'b1 || ALUResult !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL mult_mfhi: valid=%b result=%h, required 1 ffffffff", out_valid, ALUResult);
    end
    issue(ALU_MFLO, 32'h0, 32'h0, 5'd0);
    checks++;
    if (ALUResult !== 32'hFFFF_FFEB) begin
      failures++;
      $display("FAIL mult_mflo: result=%h, required ffffffeb", ALUResult);
    end
    issue(ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    wait_out(n);
    checks++;
    if (out_valid !== 1'b1 || ALUResult !== 32'h0000_0001) begin
      failures++;
      $display("FAIL multu_lo: valid=%b result=%h, required 1 00000001", out_valid, ALUResult);
    end
    issue(ALU_MFHI, 32'h0, 32'h0, 5'd0);
    checks++;
    if (ALUResult !== 32'hFFFF_FFFE) begin
      failures++;
      $display("FAIL multu_hi: result=%h, required fffffffe", ALUResult);
    end
  endtask

`ifdef ALU_MDU_DIV_EN
  task automatic test_div();
    int n;
    issue(ALU_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 5'd0);
    wait_out(n);
    checks++;
    if (out_valid !== 1'b1 || n != 32 || ALUResult !== 32'hFFFF_FFFD || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL div_q: valid=%b wait=%0d result=%h dbz=%b, required 1 32 fffffffd 0",
               out_valid, n, ALUResult, div_by_zero);
    end
    issue(ALU_MFHI, 32'h0, 32'h0, 5'd0);
    checks++;
    if (ALUResult !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL div_r: result=%h, required ffffffff", ALUResult);
    end
    issue(ALU_DIVU, 32'h0000_0007, 32'h0000_0000, 5'd0);
    wait_out(n);
    checks++;
    if (out_valid !== 1'b1 || ALUResult !== 32'hFFFF_FFFF || div_by_zero !== 1'b1 || illegal !== 1'b0) begin
      failures++;
      $display("FAIL divu_zero: valid=%b result=%h dbz=%b illegal=%b, required 1 ffffffff 1 0",
               out_valid, ALUResult, div_by_zero, illegal);
    end
    issue(ALU_MFHI, 32'h0, 32'h0, 5'd0);
    checks++;
    if (ALUResult !== 32'h0000_0007 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL divu_zero_hi: result=%h dbz=%b, required 00000007 0", ALUResult, div_by_zero);
    end
    issue(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
    wait_out(n);
    checks++;
    if (out_valid !== 1'b1 || ALUResult !== 32'h8000_0000 || div_by_zero !== 1'b0 || illegal !== 1'b0) begin
      failures++;
      $display("FAIL div_ovf: valid=%b result=%h dbz=%b illegal=%b, required 1 80000000 0 0",
               out_valid, ALUResult, div_by_zero, illegal);
    end
    issue(ALU_MFHI, 32'h0, 32'h0, 5'd0);
    checks++;
    if (ALUResult !== 32'h0) begin
      failures++;
      $display("FAIL div_ovf_hi: result=%h, required 00000000", ALUResult);
    end
  endtask
`else
  task automatic test_div();
    // HI/LO hold fffffffe/00000001 from the preceding MULTU.
    issue(ALU_DIV, 32'h0000_0064, 32'h0000_0007, 5'd0);
    checks++;
    if (out_valid !== 1'b1 || illegal !== 1'b1 || ALUResult !== 32'h0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL div_disabled: valid=%b illegal=%b result=%h ready=%b, required 1 1 00000000 1",
               out_valid, illegal, ALUResult, in_ready);
    end
    issue(ALU_MFHI, 32'h0, 32'h0, 5'd0);
    checks++;
    if (ALUResult !== 32'hFFFF_FFFE) begin
      failures++;
      $display("FAIL div_disabled_hi: result=%h, required fffffffe", ALUResult);
    end
    issue(ALU_MFLO, 32'h0, 32'h0, 5'd0);
    checks++;
    if (ALUResult !== 32'h0000_0001) begin
      failures++;
      $display("FAIL div_disabled_lo: result=%h, required 00000001", ALUResult);
    end
  endtask
`endif

  task automatic test_reset_mid();
    int seen;
    issue(ALU_MULT, 32'h0000_0005, 32'h0000_0006, 5'd0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_ready: ready=%b valid=%b, required 1 0", in_ready, out_valid);
    end
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid !== 1'b0) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL rst_mid_novalid: out_valid seen %0d times, required 0", seen);
    end
    issue(ALU_MFLO, 32'h0, 32'h0, 5'd0);
    checks++;
    if (out_valid !== 1'b1 || ALUResult !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid_lo: valid=%b result=%h, required 1 00000000", out_valid, ALUResult);
    end
    issue(ALU_MFHI, 32'h0, 32'h0, 5'd0);
    checks++;
    if (ALUResult !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid_hi: result=%h, required 00000000", ALUResult);
    end
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_back_to_back();
    test_reserved();
    test_mult();
    test_div();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
